// File: rtl/hex_scan_pkg.sv
// Shared types and default constants for the hex display scan controller.
// Build option: HEX_SCAN_LZB_EN enables leading-zero blanking in hex_scan_controller.
package hex_scan_pkg;

    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned DEF_NUM_DIGITS   = 4;
    localparam int unsigned DEF_TICK_DIV     = 50000;
    localparam int unsigned DEF_BLANK_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/scan_slot_timer.sv
// Per-digit slot counter: counts 1..TICK_DIV within a slot and flags the end of
// the blanking gap and the end of the slot. Held at 0 while clear is asserted.
module scan_slot_timer
    import hex_scan_pkg::*;
#(
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic blank_done,
    output logic slot_done
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SLOT  = CNT_W'(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // The first cycle of every slot reads 1, so the gap ends when cnt hits BLANK_CYCLES.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt == CNT_SLOT) begin
            cnt <= CNT_FIRST;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign blank_done = (cnt == CNT_BLANK);
    assign slot_done  = (cnt == CNT_SLOT);

endmodule

// File: rtl/hex_scan_controller.sv
// Time-multiplexed hex display scanner with double-buffered load handshake.
// Build option: define HEX_SCAN_LZB_EN for leading-zero blanking.
module hex_scan_controller
    import hex_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
    input  logic                          load,
    output logic                          load_ack,
    output logic [DIGIT_W-1:0]            hex_nibble,
    output logic                          seg_blank,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic                          frame_done
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = DIGIT_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_e          state, state_next;
    logic [IDX_W-1:0]     digit, digit_next;
    logic [VAL_W-1:0]     disp_val, pend_val;
    logic                 pend_valid;
    logic                 blank_done, slot_done;
    logic                 scan_clear;
    logic                 frame_edge;
    logic                 commit_point;
    logic                 show_digit;
    logic [DIGIT_W-1:0]   digit_val;

    assign scan_clear = (state_next == IDLE);

    scan_slot_timer #(
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (scan_clear),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

    always_comb begin
        state_next = state;
        digit_next = digit;
        frame_edge = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            digit_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = BLANK;
                    digit_next = '0;
                end
                BLANK: begin
                    if (blank_done) begin
                        state_next = DRIVE;
                    end
                end
                DRIVE: begin
                    if (slot_done) begin
                        state_next = BLANK;
                        if (digit == LAST_IDX) begin
                            digit_next = '0;
                            frame_edge = 1'b1;
                        end else begin
                            digit_next = digit + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    digit_next = '0;
                end
            endcase
        end
    end

    // Commits only happen on edges leading into BLANK or IDLE, so whenever the
    // next state is DRIVE the current display register is the one to show.
    assign commit_point = (state == IDLE) || frame_edge;
    assign digit_val    = disp_val[DIGIT_W*digit_next +: DIGIT_W];

`ifdef HEX_SCAN_LZB_EN
    logic [IDX_W-1:0] msd;

    always_comb begin
        msd = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            if (disp_val[DIGIT_W*i +: DIGIT_W] != '0) begin
                msd = IDX_W'(i);
            end
        end
    end

    assign show_digit = (digit_next <= msd);
`else
    assign show_digit = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            digit      <= '0;
            anode_n    <= '1;
            seg_blank  <= 1'b1;
            hex_nibble <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            digit      <= digit_next;
            frame_done <= frame_edge;
            if ((state_next == DRIVE) && show_digit) begin
                anode_n    <= ~(NUM_DIGITS'(1) << digit_next);
                seg_blank  <= 1'b0;
                hex_nibble <= digit_val;
            end else begin
                anode_n    <= '1;
                seg_blank  <= 1'b1;
                hex_nibble <= '0;
            end
        end
    end

    // A load landing on a commit point goes straight to the display register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_val   <= '0;
            pend_val   <= '0;
            pend_valid <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (commit_point) begin
                if (load) begin
                    disp_val   <= value_in;
                    pend_valid <= 1'b0;
                    load_ack   <= 1'b1;
                end else if (pend_valid) begin
                    disp_val   <= pend_val;
                    pend_valid <= 1'b0;
                    load_ack   <= 1'b1;
                end
            end else if (load) begin
                pend_val   <= value_in;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_controller.sv
// Self-checking bench for hex_scan_controller (4 digits, 8-cycle slots, 2-cycle gap).
// Honours HEX_SCAN_LZB_EN in its expectations.
module tb_hex_scan_controller;

    localparam int ND    = 4;
    localparam int TD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * TD;

    logic        clk = 1'b0;
    logic        rst_n, enable, load;
    logic [15:0] value_in;
    logic        load_ack, seg_blank, frame_done;
    logic [3:0]  hex_nibble, anode_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hex_scan_controller #(
        .NUM_DIGITS   (ND),
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .value_in   (value_in),
        .load       (load),
        .load_ack   (load_ack),
        .hex_nibble (hex_nibble),
        .seg_blank  (seg_blank),
        .anode_n    (anode_n),
        .frame_done (frame_done)
    );

    // Reference model: scan position is "cycles since scanning started".
    bit          m_run;
    int          m_t;
    logic [15:0] m_disp, m_pend;
    bit          m_pv, m_ack, m_fd;

    logic [3:0]  seen_lit;
    int          ack_count;
    int          cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_shown(input int d);
`ifdef HEX_SCAN_LZB_EN
        return (d == 0) || ((m_disp >> (4 * d)) != 16'h0);
`else
        return (d >= 0);
`endif
    endfunction

    task automatic model_edge();
        bit boundary, commit;
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_disp = '0; m_pend = '0;
            m_pv = 0; m_ack = 0; m_fd = 0;
        end else begin
            boundary = m_run && enable && ((m_t % FRAME) == FRAME - 1);
            commit   = !m_run || boundary;
            m_ack    = commit && (load || m_pv);
            m_fd     = boundary;
            if (commit) begin
                if (load) m_disp = value_in;
                else if (m_pv) m_disp = m_pend;
                m_pv = 0;
            end else if (load) begin
                m_pend = value_in;
                m_pv   = 1;
            end
            if (!enable) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic step();
        int         d;
        bit         driven;
        logic [3:0] e_an, e_nib;
        logic [15:0] sh;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        d      = (m_t / TD) % ND;
        driven = m_run && ((m_t % TD) >= BC) && m_shown(d);
        sh     = m_disp >> (4 * d);
        e_an   = driven ? ~(4'b0001 << d) : 4'hF;
        e_nib  = driven ? sh[3:0] : 4'h0;
        check("anode_n",    anode_n,    e_an);
        check("seg_blank",  seg_blank,  !driven);
        check("hex_nibble", hex_nibble, e_nib);
        check("load_ack",   load_ack,   m_ack);
        check("frame_done", frame_done, m_fd);
        seen_lit  = seen_lit | ~anode_n;
        ack_count = ack_count + int'(load_ack);
    endtask

    typedef struct {
        logic        rst_n, en, ld;
        logic [15:0] val;
        int          cycles;
        logic [3:0]  an;
        logic        sb;
        logic [3:0]  nib;
        logic        ack, fd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev_fd, n_fd;
        rst_n = 0; enable = 0; load = 0; value_in = '0;
        seen_lit = '0; ack_count = 0; cyc = 0;

        //              rst en ld  val       n  an     sb    nib    ack   fd
        vecs.push_back('{1'b0,1'b0,1'b0,16'h0000,3,4'hF,1'b1,4'h0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b1,16'hBEEF,1,4'hF,1'b1,4'h0,1'b1,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,16'h0000,1,4'hF,1'b1,4'h0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,2,4'hF,1'b1,4'h0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,6,4'hE,1'b0,4'hF,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,2,4'hF,1'b1,4'h0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,6,4'hD,1'b0,4'hE,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,2,4'hF,1'b1,4'h0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,6,4'hB,1'b0,4'hE,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,2,4'hF,1'b1,4'h0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,6,4'h7,1'b0,4'hB,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,1,4'hF,1'b1,4'h0,1'b0,1'b1});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,1,4'hF,1'b1,4'h0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,1,4'hE,1'b0,4'hF,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,16'h0000,1,4'hF,1'b1,4'h0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,2,4'hF,1'b1,4'h0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,6,4'hE,1'b0,4'hF,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,16'h0000,1,4'hF,1'b1,4'h0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,2,4'hF,1'b1,4'h0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,6,4'hE,1'b0,4'h0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,2,4'hF,1'b1,4'h0,1'b0,1'b0});
`ifdef HEX_SCAN_LZB_EN
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,6,4'hF,1'b1,4'h0,1'b0,1'b0});
`else
        vecs.push_back('{1'b1,1'b1,1'b0,16'h0000,6,4'hD,1'b0,4'h0,1'b0,1'b0});
`endif

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; enable = vecs[i].en;
            load  = vecs[i].ld;    value_in = vecs[i].val;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step();
                check("tbl_anode",  anode_n,    vecs[i].an);
                check("tbl_blank",  seg_blank,  vecs[i].sb);
                check("tbl_nibble", hex_nibble, vecs[i].nib);
                check("tbl_ack",    load_ack,   vecs[i].ack);
                check("tbl_fd",     frame_done, vecs[i].fd);
            end
        end
        load = 0;

        // Mid-frame loads: old value holds until the frame boundary, last load wins.
        rst_n = 0; enable = 0; step(); rst_n = 1;
        load = 1; value_in = 16'hBEEF; step(); load = 0;
        enable = 1;
        repeat (10) step();
        load = 1; value_in = 16'h1234; ack_count = 0; step(); load = 0;
        check("mid_d1_old", hex_nibble, 4'hE);
        repeat (13) step();
        check("mid_d2_old", hex_nibble, 4'hE);
        load = 1; value_in = 16'h5678; step(); load = 0;
        repeat (7) step();
        check("mid_d3_old", hex_nibble, 4'hB);
        check("mid_no_early_ack", ack_count, 0);
        step();
        check("mid_ack", load_ack, 1'b1);
        check("mid_fd",  frame_done, 1'b1);
        repeat (2) step();
        check("mid_new_d0", hex_nibble, 4'h8);
        repeat (24) step();
        check("mid_new_d3", hex_nibble, 4'h5);
        check("mid_one_ack", ack_count, 1);

        // frame_done period
        rst_n = 0; step(); rst_n = 1; enable = 1;
        prev_fd = -1; n_fd = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (frame_done) begin
                if (prev_fd >= 0) check("fd_period", cyc - prev_fd, FRAME);
                prev_fd = cyc; n_fd++;
            end
        end
        check("fd_count", n_fd, 3);

        // Leading-zero blanking
        rst_n = 0; step(); rst_n = 1; enable = 0;
        load = 1; value_in = 16'h0042; step(); load = 0;
        enable = 1; seen_lit = '0;
        repeat (FRAME) step();
`ifdef HEX_SCAN_LZB_EN
        check("lzb_0042", seen_lit, 4'b0011);
`else
        check("lzb_0042", seen_lit, 4'b1111);
`endif
        enable = 0; step();
        load = 1; value_in = 16'h0000; step(); load = 0;
        enable = 1; seen_lit = '0;
        repeat (FRAME) step();
`ifdef HEX_SCAN_LZB_EN
        check("lzb_0000", seen_lit, 4'b0001);
`else
        check("lzb_0000", seen_lit, 4'b1111);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 499) != 0);
            enable   = ($urandom_range(0, 99) < 97);
            load     = ($urandom_range(0, 9) == 0);
            value_in = 16'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
